// File: rtl/pwm_pkg.sv
// Shared PWM definitions: ramp FSM state encoding and default datapath widths.
package pwm_pkg;

   localparam int unsigned DW_DEF = 16;
   localparam int unsigned IW_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAMP = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : pwm_pkg

// File: rtl/pwm_sat_step.sv
// Combinational step of a duty value toward a target, saturating at the target (no wrap).
module pwm_sat_step #(
   parameter int unsigned DW = pwm_pkg::DW_DEF
) (
   input  logic [DW-1:0] cur_i,
   input  logic [DW-1:0] tgt_i,
   input  logic [DW-1:0] step_i,
   output logic [DW-1:0] next_c_o
);

   logic [DW:0] sum_c;
   logic [DW:0] diff_c;
   logic [DW:0] tgt_x_c;

   assign sum_c   = {1'b0, cur_i} + {1'b0, step_i};
   assign diff_c  = {1'b0, cur_i} - {1'b0, step_i};
   assign tgt_x_c = {1'b0, tgt_i};

   // Extra bit catches carry/borrow so the step clamps at the target instead of wrapping.
   always_comb begin
      next_c_o = tgt_i;
      if (step_i != '0) begin
         if (tgt_i > cur_i) begin
            if (sum_c < tgt_x_c) next_c_o = sum_c[DW-1:0];
         end else if (tgt_i < cur_i) begin
            if (!diff_c[DW] && (diff_c > tgt_x_c)) next_c_o = diff_c[DW-1:0];
         end
      end
   end

endmodule : pwm_sat_step

// File: rtl/pwm_dc_ramp.sv
// Duty-cycle soft-start generator: steps o_DC toward a latched target at a fixed interval,
// emitting each new value as a one-cycle valid pulse for the downstream PWM timer.
module pwm_dc_ramp
   import pwm_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned IW = IW_DEF
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic          i_preset,
   input  logic          i_abort,
   input  logic [DW-1:0] i_target,
   input  logic [DW-1:0] i_step,
   input  logic [IW-1:0] i_interval,
   output logic [DW-1:0] o_DC,
   output logic          o_DC_valid,
   output logic          o_busy,
   output logic          o_done
);

   state_e        state_q, state_d;
   logic [DW-1:0] dc_q, dc_d;
   logic [DW-1:0] tgt_q, tgt_d;
   logic [DW-1:0] step_q, step_d;
   logic [IW-1:0] ivl_q, ivl_d;
   logic [IW-1:0] cnt_q, cnt_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [DW-1:0] next_c;

   pwm_sat_step #(.DW(DW)) u_sat_step (
      .cur_i    (dc_q),
      .tgt_i    (tgt_q),
      .step_i   (step_q),
      .next_c_o (next_c)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= IDLE;
         dc_q    <= '0;
         tgt_q   <= '0;
         step_q  <= '0;
         ivl_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dc_q    <= dc_d;
         tgt_q   <= tgt_d;
         step_q  <= step_d;
         ivl_q   <= ivl_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and output logic; abort always wins and never produces a valid or done.
   always_comb begin
      state_d = state_q;
      dc_d    = dc_q;
      tgt_d   = tgt_q;
      step_d  = step_q;
      ivl_d   = ivl_q;
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (i_abort) begin
               state_d = IDLE;
            end else if (i_preset) begin
               dc_d    = i_target;
               valid_d = 1'b1;
            end else if (i_start) begin
               tgt_d   = i_target;
               step_d  = i_step;
               ivl_d   = i_interval;
               cnt_d   = i_interval;
               state_d = (i_target == dc_q) ? DONE : RAMP;
            end
         end
         RAMP: begin
            if (i_abort) begin
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - IW'(1);
            end else begin
               dc_d    = next_c;
               valid_d = 1'b1;
               cnt_d   = ivl_q;
               if (next_c == tgt_q) state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            done_d  = !i_abort;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RAMP);
   end

   assign o_DC       = dc_q;
   assign o_DC_valid = valid_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;

endmodule : pwm_dc_ramp

// File: tb/tb_pwm_dc_ramp.sv
// Directed bench for pwm_dc_ramp: valid values/timing, done pulse, saturation, abort and reset.
module tb_pwm_dc_ramp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, preset, abort;
   logic [15:0] target, step;
   logic [15:0] interval;
   logic [15:0] dc;
   logic        dc_valid, busy, done;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int vq[$];
   int vt[$];
   int dt[$];

   always #5 clk = ~clk;

   pwm_dc_ramp dut (
      .i_clk      (clk),
      .i_rst      (rst_n),
      .i_start    (start),
      .i_preset   (preset),
      .i_abort    (abort),
      .i_target   (target),
      .i_step     (step),
      .i_interval (interval),
      .o_DC       (dc),
      .o_DC_valid (dc_valid),
      .o_busy     (busy),
      .o_done     (done)
   );

   // Advance one edge, sample 1ns later, log valid values/times and done times.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (dc_valid) begin
         vq.push_back(int'(dc));
         vt.push_back(cyc);
      end
      if (done) dt.push_back(cyc);
   endtask

   task automatic clear_log();
      vq.delete();
      vt.delete();
      dt.delete();
   endtask

   task automatic start_ramp(input int t, input int s, input int iv, output int e);
      target   = 16'(t);
      step     = 16'(s);
      interval = 16'(iv);
      start    = 1'b1;
      tick();
      start = 1'b0;
      e     = cyc;
   endtask

   task automatic do_preset(input int v);
      target = 16'(v);
      preset = 1'b1;
      tick();
      preset = 1'b0;
      total++;
      if (dc !== 16'(v) || dc_valid !== 1'b1) $display("FAIL preset: dc=%0h valid=%0b expected dc=%0h valid=1", dc, dc_valid, v);
      else passed++;
      tick();
   endtask

   task automatic test_reset();
      int e;
      rst_n = 1'b0;
      tick();
      tick();
      total++;
      if ({dc, dc_valid, busy, done} !== 19'd0) $display("FAIL reset_init: dc=%0d valid=%0b busy=%0b done=%0b expected all 0", dc, dc_valid, busy, done);
      else passed++;
      #3 rst_n = 1'b1;
      tick();
      start_ramp(100, 30, 3, e);
      repeat (6) tick();
      total++;
      if (dc !== 16'd30 || busy !== 1'b1) $display("FAIL reset_preramp: dc=%0d busy=%0b expected dc=30 busy=1", dc, busy);
      else passed++;
      #3 rst_n = 1'b0;
      #1;
      total++;
      if ({dc, dc_valid, busy, done} !== 19'd0) $display("FAIL reset_midramp: dc=%0d valid=%0b busy=%0b done=%0b expected all 0", dc, dc_valid, busy, done);
      else passed++;
      #2 rst_n = 1'b1;
      clear_log();
      repeat (10) tick();
      total++;
      if (vq.size() !== 0 || dt.size() !== 0) $display("FAIL reset_quiet: valids=%0d dones=%0d expected 0 0", vq.size(), dt.size());
      else passed++;
   endtask

   task automatic test_ramp_up();
      int e;
      int ev[4] = '{30, 60, 90, 100};
      clear_log();
      start_ramp(100, 30, 3, e);
      total++;
      if (busy !== 1'b1) $display("FAIL up_busy: busy=%0b expected 1", busy);
      else passed++;
      repeat (20) tick();
      total++;
      if (vq.size() !== 4) $display("FAIL up_count: got %0d valids expected 4", vq.size());
      else begin
         passed++;
         for (int i = 0; i < 4; i++) begin
            total++;
            if (vq[i] !== ev[i] || vt[i] !== e + 4 * (i + 1))
               $display("FAIL up_valid%0d: dc=%0d at +%0d expected %0d at +%0d", i, vq[i], vt[i] - e, ev[i], 4 * (i + 1));
            else passed++;
         end
      end
      total++;
      if (dt.size() !== 1 || dt[0] !== e + 17) $display("FAIL up_done: dones=%0d first at +%0d expected 1 at +17", dt.size(), (dt.size() > 0) ? dt[0] - e : -1);
      else passed++;
      total++;
      if (busy !== 1'b0 || dc !== 16'd100) $display("FAIL up_end: busy=%0b dc=%0d expected busy=0 dc=100", busy, dc);
      else passed++;
   endtask

   task automatic test_ramp_down();
      int e;
      int ev[3] = '{60, 20, 0};
      do_preset(100);
      clear_log();
      start_ramp(0, 40, 0, e);
      repeat (8) tick();
      total++;
      if (vq.size() !== 3) $display("FAIL down_count: got %0d valids expected 3", vq.size());
      else begin
         passed++;
         for (int i = 0; i < 3; i++) begin
            total++;
            if (vq[i] !== ev[i] || vt[i] !== e + i + 1)
               $display("FAIL down_valid%0d: dc=%0d at +%0d expected %0d at +%0d", i, vq[i], vt[i] - e, ev[i], i + 1);
            else passed++;
         end
      end
      total++;
      if (dt.size() !== 1 || dt[0] !== e + 4) $display("FAIL down_done: dones=%0d expected 1 at +4", dt.size());
      else passed++;
   endtask

   task automatic test_saturation();
      int e;
      do_preset(16'hFFF0);
      clear_log();
      start_ramp(16'hFFFF, 16'h0020, 0, e);
      repeat (5) tick();
      total++;
      if (vq.size() !== 1 || vq[0] !== 16'hFFFF || vt[0] !== e + 1)
         $display("FAIL sat_high: valids=%0d first=%0h expected 1 valid of ffff at +1", vq.size(), (vq.size() > 0) ? vq[0] : -1);
      else passed++;
      total++;
      if (dt.size() !== 1) $display("FAIL sat_high_done: dones=%0d expected 1", dt.size());
      else passed++;
      do_preset(16'h0010);
      clear_log();
      start_ramp(0, 16'h0020, 0, e);
      repeat (5) tick();
      total++;
      if (vq.size() !== 1 || vq[0] !== 0 || dc !== 16'd0)
         $display("FAIL sat_low: valids=%0d first=%0h dc=%0h expected 1 valid of 0", vq.size(), (vq.size() > 0) ? vq[0] : -1, dc);
      else passed++;
   endtask

   task automatic test_abort();
      int e;
      clear_log();
      start_ramp(100, 30, 2, e);
      while (cyc < e + 6) tick();
      total++;
      if (vq.size() !== 2 || dc !== 16'd60) $display("FAIL abort_pre: valids=%0d dc=%0d expected 2 and 60", vq.size(), dc);
      else passed++;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++;
      if (busy !== 1'b0 || dc !== 16'd60) $display("FAIL abort_busy: busy=%0b dc=%0d expected 0 and 60", busy, dc);
      else passed++;
      repeat (10) tick();
      total++;
      if (vq.size() !== 2 || dt.size() !== 0 || dc !== 16'd60)
         $display("FAIL abort_after: valids=%0d dones=%0d dc=%0d expected 2 0 60", vq.size(), dt.size(), dc);
      else passed++;
      clear_log();
      abort = 1'b1;
      start_ramp(200, 10, 0, e);
      abort = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_start: busy=%0b done=%0b expected 0 0", busy, done);
      else passed++;
      repeat (4) tick();
      total++;
      if (vq.size() !== 0 || dt.size() !== 0 || dc !== 16'd60)
         $display("FAIL abort_start_quiet: valids=%0d dones=%0d dc=%0d expected 0 0 60", vq.size(), dt.size(), dc);
      else passed++;
   endtask

   task automatic test_jump_and_ignore();
      int e;
      clear_log();
      start_ramp(500, 0, 4, e);
      tick();
      target = 16'd7;
      start  = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      total++;
      if (vq.size() !== 1 || vq[0] !== 500 || vt[0] !== e + 5)
         $display("FAIL jump: valids=%0d first=%0d at +%0d expected 500 at +5", vq.size(), (vq.size() > 0) ? vq[0] : -1, (vt.size() > 0) ? vt[0] - e : -1);
      else passed++;
      total++;
      if (dt.size() !== 1 || dt[0] !== e + 6 || dc !== 16'd500)
         $display("FAIL jump_done: dones=%0d dc=%0d expected 1 at +6 and dc=500", dt.size(), dc);
      else passed++;
      clear_log();
      start_ramp(500, 3, 2, e);
      total++;
      if (busy !== 1'b0) $display("FAIL equal_busy: busy=%0b expected 0", busy);
      else passed++;
      repeat (4) tick();
      total++;
      if (vq.size() !== 0 || dt.size() !== 1 || dt[0] !== e + 1)
         $display("FAIL equal_done: valids=%0d dones=%0d expected 0 valids 1 done at +1", vq.size(), dt.size());
      else passed++;
   endtask

   initial begin
      start    = 1'b0;
      preset   = 1'b0;
      abort    = 1'b0;
      target   = '0;
      step     = '0;
      interval = '0;
      test_reset();
      test_ramp_up();
      test_ramp_down();
      test_saturation();
      test_abort();
      test_jump_and_ignore();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_pwm_dc_ramp
